linear_write_data_streamer: RTL and testbench
=============================================

Name: linear_write_data_streamer

Overview:
- W/B-channel companion to the linear AXI address generator.
- Takes a range [startAddr, endAddr), computes the number of fixed-size bursts, and streams payload beats from an upstream AXI-Stream source onto the AXI4 W channel, with wlast per burst.
- Counts B responses and raises done once every burst is acknowledged.
- Runs concurrently with the address generator; the same start, startAddr and endAddr drive both blocks.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- ID_WIDTH, 8, width of bid.
- DATA_WIDTH, 64, W data width; must equal 8 * 2^AxSIZE_BYTES_PER_BEAT.
- AxLEN_BEATS_PER_TRANSFER, 15, beats per burst minus one (must match the address generator).
- AxSIZE_BYTES_PER_BEAT, 3, log2 of bytes per beat.

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  starts a transfer; accepted only while done=1.
- done  out  1  high when idle or finished.
- error  out  1  sticky: some bresp != OKAY in the current transfer.
- startAddr  in  ADDR_WIDTH  first byte address.
- endAddr  in  ADDR_WIDTH  exclusive end byte address.
- s_tdata  in  DATA_WIDTH  payload beat.
- s_tvalid  in  1  payload valid.
- s_tready  out  1  payload accepted.
- wdata  out  DATA_WIDTH  W data.
- wstrb  out  DATA_WIDTH/8  W strobes.
- wlast  out  1  last beat of burst.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- bid  in  ID_WIDTH  ignored (single ID 0).
- bresp  in  2  write response.
- bvalid  in  1  B valid.
- bready  out  1  B ready.

Behaviour:
- Reset values: done=1, error=0, wvalid=0, wlast=0, wstrb=0, bready=0, s_tready=0, state=IDLE, all counters 0. Reset mid-operation aborts immediately, with no draining.
- BURST_BYTES = 2^AxSIZE_BYTES_PER_BEAT * (AxLEN_BEATS_PER_TRANSFER+1).
- Burst count: nBursts = (endAddr - startAddr) >> log2(BURST_BYTES), ADDR_WIDTH wide, modulo-2^ADDR_WIDTH subtraction. Low remainder bits are discarded.
- States and transitions:
  - IDLE: on start && done, latch wRemaining = bRemaining = nBursts and clear error.
    - nBursts == 0: stay in IDLE with done=1.
    - Otherwise: done<=0 next cycle, go to STREAM.
    - start while done=0 is ignored.
  - STREAM: W is a single-entry register slice (wdata/wvalid/wlast/wstrb all registered).
    - s_tready = !wvalid || wready.
    - s_tdata is loaded on s_tvalid && s_tready.
    - wstrb is all ones for real data.
    - beatCnt counts 0..AxLEN_BEATS_PER_TRANSFER; wlast=1 on the beat loaded with beatCnt==AxLEN.
    - On the W handshake with wlast=1, wRemaining decrements.
    - When wRemaining reaches 0, s_tready=0 and the state goes to DRAIN once the final beat has been accepted.
  - DRAIN: waits for outstanding B responses.
    - bRemaining==0: done<=1, go to IDLE.
- Output stability: wvalid, once asserted, holds with stable payload until wready (AXI rule). No beat is dropped or duplicated under arbitrary s_tvalid/wready gaps.
- bready=1 in STREAM and DRAIN. Each bvalid handshake decrements bRemaining; any bresp != 0 sets error, which holds until the next accepted start.
- B before its W: a B handshake arriving before the matching wlast is counted anyway (counters are independent). bRemaining never underflows; extra B beats while bRemaining==0 are accepted and ignored.
- Latency:
  - First wvalid appears 2 cycles after start when s_tvalid is already high.
  - done rises 1 cycle after the final B handshake.

Optional Feature:
- Macro: LINEAR_WRITE_PARTIAL_BURST_EN.
- Defined: nBursts rounds up (ceil). On the final burst, the beats beyond the payload byte count are padded with wvalid=1, wstrb=0 and wdata=0, without consuming s_tdata. The payload byte count is assumed beat-aligned. The caller must round endAddr up to BURST_BYTES for the address generator.
- Undefined: truncation as described in Behaviour; partial tails are never written.

Decomposition:
- Package linear_axi_pkg:
  - AXI resp constants: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - State enum: IDLE, STREAM, DRAIN.
  - burst_bytes(len, size) constant function.
- One sub-module, axi_w_register_slice: the one-entry W output register with valid/ready.
- Counters and FSM stay in the top module.

Test Plan:
- Basic run: startAddr=0x0, endAddr=0x200, continuous s_tvalid, wready=1 -> 4 bursts, 64 W beats, wlast on beats 15/31/47/63, data in order. done=1 one cycle after the 4th B.
- Empty range: startAddr=endAddr=0x1000 -> done stays 1; wvalid and s_tready never assert.
- Backpressure: random wready (50%) and s_tvalid gaps, range 0x0..0x100 -> exactly 32 beats in order, wdata stable while wvalid && !wready.
- Error response: bresp=2 on the 2nd of 4 B -> error=1 from that cycle, done still rises after the 4th B. The next start clears error.
- Reset mid-operation: reset after 10 W beats -> next cycle done=1, wvalid=0, bready=0, s_tready=0. A fresh start of 0x0..0x80 completes 16 beats.
- Partial tail (macro defined): range 0x0..0x140 -> 3 bursts. Final burst has 8 data beats plus 8 wstrb=0 pad beats, and s_tready stays low during the pads.

Source files
------------

// File: rtl/linear_axi_pkg.sv
// linear_axi_pkg: shared definitions for the linear AXI write-side blocks.
//   - AXI response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   - FSM state type for the write data streamer
//   - burst_bytes(): bytes moved by one fixed-size burst
package linear_axi_pkg;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // (len + 1) beats of 2^size bytes each
  function automatic int unsigned burst_bytes(input int unsigned len,
                                              input int unsigned size);
    return (len + 1) << size;
  endfunction

endpackage

// File: rtl/axi_w_register_slice.sv
// axi_w_register_slice: one-entry registered AXI4 W channel output stage.
// Ports:
//   aclk, reset              clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready = !wvalid || wready)
//   in_data/in_strb/in_last  beat to load
//   wdata/wstrb/wlast/wvalid registered W channel outputs
//   wready                   W channel ready from the slave
module axi_w_register_slice #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  input  logic                    in_last,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready
);

  // The register can take a new beat when empty or when its beat leaves now.
  assign in_ready = !wvalid || wready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      wvalid <= 1'b0;
      wlast  <= 1'b0;
      wstrb  <= '0;
      wdata  <= '0;
    end else if (in_ready) begin
      wvalid <= in_valid;
      wlast  <= in_valid && in_last;
      wstrb  <= in_valid ? in_strb : '0;
      if (in_valid) begin
        wdata <= in_data;
      end
    end
  end

endmodule

// File: rtl/linear_write_data_streamer.sv
// linear_write_data_streamer: W/B channel companion to the linear AXI address
// generator. Splits [startAddr, endAddr) into fixed-size bursts, streams
// AXI-Stream payload beats onto the AXI4 W channel with wlast per burst, and
// counts B responses until every burst is acknowledged.
// Ports:
//   aclk, reset            clock, synchronous active-high reset
//   start, done, error     control/status (start accepted only while done=1;
//                          error is sticky for the current transfer)
//   startAddr, endAddr     byte range, end exclusive
//   s_tdata/s_tvalid/s_tready  payload stream in
//   wdata/wstrb/wlast/wvalid/wready  AXI4 W channel
//   bid/bresp/bvalid/bready          AXI4 B channel (bid ignored)
// Build option: LINEAR_WRITE_PARTIAL_BURST_EN rounds the burst count up and
// pads the final burst with wstrb=0 beats instead of truncating the tail.
module linear_write_data_streamer
  import linear_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH               = 32,
  parameter int unsigned ID_WIDTH                 = 8,
  parameter int unsigned DATA_WIDTH               = 64,
  parameter int unsigned AxLEN_BEATS_PER_TRANSFER = 15,
  parameter int unsigned AxSIZE_BYTES_PER_BEAT    = 3
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    done,
  output logic                    error,
  input  logic [ADDR_WIDTH-1:0]   startAddr,
  input  logic [ADDR_WIDTH-1:0]   endAddr,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned BURST_SHIFT =
    $clog2(burst_bytes(AxLEN_BEATS_PER_TRANSFER, AxSIZE_BYTES_PER_BEAT));
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   wRemaining;     // bursts not yet handshaken on W
  logic [ADDR_WIDTH-1:0]   bRemaining;     // bursts not yet acknowledged on B
  logic [ADDR_WIDTH-1:0]   loadRemaining;  // bursts not yet loaded into the slice
  logic [7:0]              beatCnt;

  logic [ADDR_WIDTH-1:0]   span;
  logic [ADDR_WIDTH-1:0]   nBursts;
  logic                    feeding;
  logic                    pad_beat;
  logic                    last_beat;
  logic                    slice_valid;
  logic                    slice_ready;
  logic                    load;
  logic                    w_hs;
  logic                    b_hs;
  logic [DATA_WIDTH-1:0]   slice_data;
  logic [STRB_WIDTH-1:0]   slice_strb;
  logic                    unused_bid;

  assign unused_bid = ^bid;
  assign span       = endAddr - startAddr;

`ifdef LINEAR_WRITE_PARTIAL_BURST_EN
  logic [ADDR_WIDTH-1:0]   payloadRemaining;  // payload beats still to take from s_*
  logic                    tail;

  assign tail     = |span[BURST_SHIFT-1:0];
  assign nBursts  = (span >> BURST_SHIFT) + ADDR_WIDTH'(tail);
  assign pad_beat = feeding && (payloadRemaining == '0);
`else
  assign nBursts  = span >> BURST_SHIFT;
  assign pad_beat = 1'b0;
`endif

  // Loading is tracked separately from W handshakes so that s_tready drops as
  // soon as the final beat is in the slice, not when it leaves it.
  assign feeding     = (state == STREAM) && (loadRemaining != '0);
  assign last_beat   = (beatCnt == 8'(AxLEN_BEATS_PER_TRANSFER));
  assign s_tready    = feeding && !pad_beat && slice_ready;
  assign slice_valid = pad_beat || (feeding && s_tvalid);
  assign slice_data  = pad_beat ? '0 : s_tdata;
  assign slice_strb  = pad_beat ? '0 : '1;
  assign load        = slice_valid && slice_ready;
  assign w_hs        = wvalid && wready;
  assign bready      = (state == STREAM) || (state == DRAIN);
  assign b_hs        = bvalid && bready;

  axi_w_register_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_w_slice (
    .aclk     (aclk),
    .reset    (reset),
    .in_valid (slice_valid),
    .in_ready (slice_ready),
    .in_data  (slice_data),
    .in_strb  (slice_strb),
    .in_last  (last_beat),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready)
  );

  always_ff @(posedge aclk) begin
    if (reset) begin
      state         <= IDLE;
      done          <= 1'b1;
      error         <= 1'b0;
      wRemaining    <= '0;
      bRemaining    <= '0;
      loadRemaining <= '0;
      beatCnt       <= '0;
`ifdef LINEAR_WRITE_PARTIAL_BURST_EN
      payloadRemaining <= '0;
`endif
    end else begin
      if (load) begin
        beatCnt <= last_beat ? '0 : beatCnt + 8'd1;
        if (last_beat) begin
          loadRemaining <= loadRemaining - ADDR_WIDTH'(1);
        end
      end
`ifdef LINEAR_WRITE_PARTIAL_BURST_EN
      if (s_tvalid && s_tready) begin
        payloadRemaining <= payloadRemaining - ADDR_WIDTH'(1);
      end
`endif
      if (w_hs && wlast && (wRemaining != '0)) begin
        wRemaining <= wRemaining - ADDR_WIDTH'(1);
      end
      // B may overtake its W burst; extra responses past zero are swallowed.
      if (b_hs) begin
        if (bRemaining != '0) begin
          bRemaining <= bRemaining - ADDR_WIDTH'(1);
        end
        if (bresp != OKAY) begin
          error <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start && done) begin
            error         <= 1'b0;
            wRemaining    <= nBursts;
            bRemaining    <= nBursts;
            loadRemaining <= nBursts;
            beatCnt       <= '0;
`ifdef LINEAR_WRITE_PARTIAL_BURST_EN
            payloadRemaining <= span >> AxSIZE_BYTES_PER_BEAT;
`endif
            if (nBursts != '0) begin
              done  <= 1'b0;
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_hs && wlast && (wRemaining == ADDR_WIDTH'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finishing on the final B handshake itself gives done one cycle later.
          if ((bRemaining == '0) || (b_hs && (bRemaining == ADDR_WIDTH'(1)))) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_write_data_streamer.sv
module tb_linear_write_data_streamer;

  localparam logic [63:0] DATA_BASE = 64'hD000_0000_0000_0000;

  logic        aclk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        error;
  logic [31:0] startAddr;
  logic [31:0] endAddr;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // observations filled by drive_transfer
  int unsigned obs_beats, obs_data_errs, obs_last_errs, obs_stable_errs;
  int unsigned obs_bursts, obs_src, obs_first_wvalid, obs_done_delay;
  int unsigned obs_extra_tready, obs_wvalid_cycles, obs_tready_cycles;
  logic        obs_timeout, obs_saw_done_low, obs_err_at1;
  logic        obs_err_before, obs_err_next, obs_err_final;

  linear_write_data_streamer #(
    .ADDR_WIDTH               (32),
    .ID_WIDTH                 (8),
    .DATA_WIDTH               (64),
    .AxLEN_BEATS_PER_TRANSFER (15),
    .AxSIZE_BYTES_PER_BEAT    (3)
  ) dut (
    .aclk      (aclk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .error     (error),
    .startAddr (startAddr),
    .endAddr   (endAddr),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  always #5 aclk = ~aclk;

  // Drives one transfer cycle by cycle (inputs at negedge, sampling 1 time
  // unit later) and records what the DUT did. Beat k is expected to carry
  // DATA_BASE|k with full strobes for k < data_beats, and zero data/strobes
  // after that; wlast is expected on every 16th beat.
  task automatic drive_transfer(input logic [31:0] sa, input logic [31:0] ea,
                                input int unsigned src_avail,
                                input int unsigned data_beats,
                                input int unsigned wr_pct,
                                input int unsigned tv_pct,
                                input int unsigned err_b,
                                input int unsigned abort_after);
    int unsigned src_idx = 0, b_pend = 0, b_num = 0;
    int unsigned err_cycle = 0, last_b_cycle = 0;
    logic        prev_stall = 1'b0, prev_wlast = 1'b0;
    logic [63:0] prev_wdata = '0;
    logic [7:0]  prev_wstrb = '0;
    obs_beats = 0; obs_data_errs = 0; obs_last_errs = 0; obs_stable_errs = 0;
    obs_first_wvalid = 0; obs_done_delay = 0; obs_extra_tready = 0;
    obs_wvalid_cycles = 0; obs_tready_cycles = 0;
    obs_timeout = 1'b0; obs_saw_done_low = 1'b0; obs_err_at1 = 1'b0;
    obs_err_before = 1'b0; obs_err_next = 1'b0;
    @(negedge aclk);
    startAddr = sa; endAddr = ea; start = 1'b1;
    s_tvalid = 1'b0; bvalid = 1'b0; wready = 1'b0;
    for (int unsigned c = 1; c <= 4000; c++) begin
      @(negedge aclk);
      start    = 1'b0;
      wready   = ($urandom_range(99) < wr_pct);
      s_tvalid = (src_idx < src_avail) && ($urandom_range(99) < tv_pct);
      s_tdata  = DATA_BASE | 64'(src_idx);
      bvalid   = (b_pend != 0);
      bresp    = (bvalid && (b_num + 1 == err_b)) ? 2'd2 : 2'd0;
      #1;
      if (c == 1) obs_err_at1 = error;
      if (!done) obs_saw_done_low = 1'b1;
      if (wvalid && obs_first_wvalid == 0) obs_first_wvalid = c;
      if (wvalid) obs_wvalid_cycles++;
      if (s_tready) obs_tready_cycles++;
      if (s_tready && src_idx >= data_beats) obs_extra_tready++;
      if (prev_stall && !(wvalid && wdata == prev_wdata && wstrb == prev_wstrb &&
                          wlast == prev_wlast))
        obs_stable_errs++;
      prev_stall = wvalid && !wready;
      prev_wdata = wdata; prev_wstrb = wstrb; prev_wlast = wlast;
      if (wvalid && wready) begin
        if (obs_beats < data_beats) begin
          if (wdata !== (DATA_BASE | 64'(obs_beats)) || wstrb !== 8'hFF) obs_data_errs++;
        end else begin
          if (wdata !== 64'd0 || wstrb !== 8'h00) obs_data_errs++;
        end
        if (wlast !== ((obs_beats % 16) == 15)) obs_last_errs++;
        if (wlast) b_pend++;
        obs_beats++;
      end
      if (s_tvalid && s_tready) src_idx++;
      if (bvalid && bready) begin
        b_pend--;
        b_num++;
        last_b_cycle = c;
        if (b_num == err_b) err_cycle = c;
      end
      if (err_cycle != 0 && c == err_cycle) obs_err_before = error;
      if (err_cycle != 0 && c == err_cycle + 1) obs_err_next = error;
      if (abort_after != 0 && obs_beats == abort_after) break;
      if (obs_saw_done_low && done) begin
        obs_done_delay = c - last_b_cycle;
        break;
      end
      if (!obs_saw_done_low && c >= 20) break;
      if (c == 4000) obs_timeout = 1'b1;
    end
    obs_bursts    = b_num;
    obs_src       = src_idx;
    obs_err_final = error;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    #1;
    n_checks++; if (done !== 1'b1)     begin n_fail++; $display("FAIL reset_done got %0b want 1", done); end
    n_checks++; if (error !== 1'b0)    begin n_fail++; $display("FAIL reset_error got %0b want 0", error); end
    n_checks++; if (wvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_wvalid got %0b want 0", wvalid); end
    n_checks++; if (wlast !== 1'b0)    begin n_fail++; $display("FAIL reset_wlast got %0b want 0", wlast); end
    n_checks++; if (wstrb !== 8'h00)   begin n_fail++; $display("FAIL reset_wstrb got %h want 00", wstrb); end
    n_checks++; if (bready !== 1'b0)   begin n_fail++; $display("FAIL reset_bready got %0b want 0", bready); end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got %0b want 0", s_tready); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    drive_transfer(32'h0, 32'h200, 64, 64, 100, 100, 0, 0);
    n_checks++; if (obs_timeout !== 1'b0)  begin n_fail++; $display("FAIL basic_timeout got %0b want 0", obs_timeout); end
    n_checks++; if (obs_beats != 64)       begin n_fail++; $display("FAIL basic_beats got %0d want 64", obs_beats); end
    n_checks++; if (obs_data_errs != 0)    begin n_fail++; $display("FAIL basic_data got %0d bad beats want 0", obs_data_errs); end
    n_checks++; if (obs_last_errs != 0)    begin n_fail++; $display("FAIL basic_wlast got %0d bad beats want 0", obs_last_errs); end
    n_checks++; if (obs_bursts != 4)       begin n_fail++; $display("FAIL basic_bursts got %0d want 4", obs_bursts); end
    n_checks++; if (obs_src != 64)         begin n_fail++; $display("FAIL basic_src got %0d want 64", obs_src); end
    n_checks++; if (obs_first_wvalid != 2) begin n_fail++; $display("FAIL basic_first_wvalid got %0d want 2", obs_first_wvalid); end
    n_checks++; if (obs_done_delay != 1)   begin n_fail++; $display("FAIL basic_done_delay got %0d want 1", obs_done_delay); end
    n_checks++; if (obs_extra_tready != 0) begin n_fail++; $display("FAIL basic_extra_tready got %0d want 0", obs_extra_tready); end
    n_checks++; if (obs_err_final !== 1'b0) begin n_fail++; $display("FAIL basic_error got %0b want 0", obs_err_final); end
  endtask

  task automatic test_empty;
    drive_transfer(32'h1000, 32'h1000, 0, 0, 100, 100, 0, 0);
    n_checks++; if (obs_saw_done_low !== 1'b0) begin n_fail++; $display("FAIL empty_done_low got %0b want 0", obs_saw_done_low); end
    n_checks++; if (obs_wvalid_cycles != 0)    begin n_fail++; $display("FAIL empty_wvalid got %0d cycles want 0", obs_wvalid_cycles); end
    n_checks++; if (obs_tready_cycles != 0)    begin n_fail++; $display("FAIL empty_s_tready got %0d cycles want 0", obs_tready_cycles); end
    n_checks++; if (done !== 1'b1)             begin n_fail++; $display("FAIL empty_done got %0b want 1", done); end
  endtask

  task automatic test_backpressure;
    drive_transfer(32'h0, 32'h100, 32, 32, 50, 60, 0, 0);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %0b want 0", obs_timeout); end
    n_checks++; if (obs_beats != 32)      begin n_fail++; $display("FAIL bp_beats got %0d want 32", obs_beats); end
    n_checks++; if (obs_data_errs != 0)   begin n_fail++; $display("FAIL bp_data got %0d bad beats want 0", obs_data_errs); end
    n_checks++; if (obs_last_errs != 0)   begin n_fail++; $display("FAIL bp_wlast got %0d bad beats want 0", obs_last_errs); end
    n_checks++; if (obs_stable_errs != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", obs_stable_errs); end
    n_checks++; if (obs_bursts != 2)      begin n_fail++; $display("FAIL bp_bursts got %0d want 2", obs_bursts); end
    n_checks++; if (obs_src != 32)        begin n_fail++; $display("FAIL bp_src got %0d want 32", obs_src); end
  endtask

  task automatic test_error_response;
    drive_transfer(32'h0, 32'h200, 64, 64, 100, 100, 2, 0);
    n_checks++; if (obs_err_before !== 1'b0) begin n_fail++; $display("FAIL err_before got %0b want 0", obs_err_before); end
    n_checks++; if (obs_err_next !== 1'b1)   begin n_fail++; $display("FAIL err_next got %0b want 1", obs_err_next); end
    n_checks++; if (obs_err_final !== 1'b1)  begin n_fail++; $display("FAIL err_sticky got %0b want 1", obs_err_final); end
    n_checks++; if (obs_bursts != 4)         begin n_fail++; $display("FAIL err_bursts got %0d want 4", obs_bursts); end
    n_checks++; if (obs_done_delay != 1)     begin n_fail++; $display("FAIL err_done_delay got %0d want 1", obs_done_delay); end
    drive_transfer(32'h0, 32'h80, 16, 16, 100, 100, 0, 0);
    n_checks++; if (obs_err_at1 !== 1'b0)    begin n_fail++; $display("FAIL err_cleared got %0b want 0", obs_err_at1); end
    n_checks++; if (obs_bursts != 1)         begin n_fail++; $display("FAIL err_next_bursts got %0d want 1", obs_bursts); end
  endtask

  task automatic test_reset_mid_operation;
    drive_transfer(32'h0, 32'h200, 64, 64, 100, 100, 0, 10);
    reset = 1'b1;
    @(negedge aclk);
    #1;
    n_checks++; if (done !== 1'b1)     begin n_fail++; $display("FAIL abort_done got %0b want 1", done); end
    n_checks++; if (wvalid !== 1'b0)   begin n_fail++; $display("FAIL abort_wvalid got %0b want 0", wvalid); end
    n_checks++; if (bready !== 1'b0)   begin n_fail++; $display("FAIL abort_bready got %0b want 0", bready); end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL abort_s_tready got %0b want 0", s_tready); end
    reset = 1'b0; s_tvalid = 1'b0; bvalid = 1'b0;
    drive_transfer(32'h0, 32'h80, 16, 16, 100, 100, 0, 0);
    n_checks++; if (obs_beats != 16)     begin n_fail++; $display("FAIL restart_beats got %0d want 16", obs_beats); end
    n_checks++; if (obs_data_errs != 0)  begin n_fail++; $display("FAIL restart_data got %0d bad beats want 0", obs_data_errs); end
    n_checks++; if (obs_bursts != 1)     begin n_fail++; $display("FAIL restart_bursts got %0d want 1", obs_bursts); end
    n_checks++; if (obs_done_delay != 1) begin n_fail++; $display("FAIL restart_done_delay got %0d want 1", obs_done_delay); end
  endtask

  task automatic test_partial_tail;
`ifdef LINEAR_WRITE_PARTIAL_BURST_EN
    // 0x140 bytes = 40 beats -> 3 bursts, last one 8 data + 8 pad beats
    drive_transfer(32'h0, 32'h140, 40, 40, 100, 100, 0, 0);
    n_checks++; if (obs_beats != 48)       begin n_fail++; $display("FAIL tail_beats got %0d want 48", obs_beats); end
    n_checks++; if (obs_bursts != 3)       begin n_fail++; $display("FAIL tail_bursts got %0d want 3", obs_bursts); end
    n_checks++; if (obs_src != 40)         begin n_fail++; $display("FAIL tail_src got %0d want 40", obs_src); end
`else
    // remainder of 0x40 bytes is dropped -> 2 bursts, 32 beats consumed
    drive_transfer(32'h0, 32'h140, 40, 32, 100, 100, 0, 0);
    n_checks++; if (obs_beats != 32)       begin n_fail++; $display("FAIL tail_beats got %0d want 32", obs_beats); end
    n_checks++; if (obs_bursts != 2)       begin n_fail++; $display("FAIL tail_bursts got %0d want 2", obs_bursts); end
    n_checks++; if (obs_src != 32)         begin n_fail++; $display("FAIL tail_src got %0d want 32", obs_src); end
`endif
    n_checks++; if (obs_data_errs != 0)    begin n_fail++; $display("FAIL tail_data got %0d bad beats want 0", obs_data_errs); end
    n_checks++; if (obs_last_errs != 0)    begin n_fail++; $display("FAIL tail_wlast got %0d bad beats want 0", obs_last_errs); end
    n_checks++; if (obs_extra_tready != 0) begin n_fail++; $display("FAIL tail_s_tready got %0d cycles want 0", obs_extra_tready); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; startAddr = '0; endAddr = '0;
    s_tdata = '0; s_tvalid = 1'b0; wready = 1'b0;
    bid = '0; bresp = 2'd0; bvalid = 1'b0;
    test_reset;
    test_basic;
    test_empty;
    test_backpressure;
    test_error_response;
    test_reset_mid_operation;
    test_partial_tail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
